// File: rtl/pc_pkg.sv
// Shared encodings for the fetch-stage program counter: next-PC select,
// exception codes and fault FSM states.
package pc_pkg;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_BR  = 2'b01,
    NPC_J   = 2'b10,
    NPC_REG = 2'b11
  } npc_sel_e;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pc_unit_if.sv
// Fetch-stage PC bus between decode/branch logic (master) and pc_unit (slave).
// fetch_cnt exists only when PC_UNIT_FETCH_CNT_EN is defined.
interface pc_unit_if #(
  parameter int unsigned W = 32
);

  logic         stall;
  logic [1:0]   npc_sel;
  logic [W-1:0] br_target;
  logic [W-1:0] j_target;
  logic [W-1:0] reg_target;
  logic         exc_req;
  logic         eret;
  logic [W-1:0] epc;
  logic [W-1:0] pc;
  logic [W-1:0] pc_plus4;
  logic         fetch_valid;
  logic         fetch_fault;
  logic [4:0]   exc_code;
`ifdef PC_UNIT_FETCH_CNT_EN
  logic [31:0]  fetch_cnt;
`endif

  modport master (
    output stall, npc_sel, br_target, j_target, reg_target, exc_req, eret, epc,
`ifdef PC_UNIT_FETCH_CNT_EN
    input  fetch_cnt,
`endif
    input  pc, pc_plus4, fetch_valid, fetch_fault, exc_code
  );

  modport slave (
    input  stall, npc_sel, br_target, j_target, reg_target, exc_req, eret, epc,
`ifdef PC_UNIT_FETCH_CNT_EN
    output fetch_cnt,
`endif
    output pc, pc_plus4, fetch_valid, fetch_fault, exc_code
  );

endinterface

// File: rtl/pc_range_chk.sv
// Fetch-address legality: misaligned or outside the inclusive [lo, hi] window.
// All comparisons are unsigned over the full address width.
module pc_range_chk #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] addr,
  input  logic [W-1:0] lo,
  input  logic [W-1:0] hi,
  output logic         illegal
);

  logic misaligned;
  logic below;
  logic above;

  assign misaligned = (addr[1:0] != 2'b00);
  assign below      = (addr < lo);
  assign above      = (addr > hi);
  assign illegal    = misaligned | below | above;

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter with next-PC mux, exception redirect and a fault
// FSM that parks on an illegal PC. Optional fetch counter: PC_UNIT_FETCH_CNT_EN.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_RUN   | normal fetch; pc follows exc_req / eret / npc_sel / stall
//   ST_FAULT | illegal pc held until CP0 takes the exception via exc_req
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned  W         = 32,
  parameter logic [W-1:0] RESET_VEC = 32'h3000,
  parameter logic [W-1:0] EXC_VEC   = 32'h4180,
  parameter logic [W-1:0] ADDR_LO   = 32'h3000,
  parameter logic [W-1:0] ADDR_HI   = 32'h4ffc
) (
  input logic     clk,
  input logic     reset,
  pc_unit_if.slave bus
);

  logic [W-1:0] pc_q;
  logic [W-1:0] pc_inc;
  logic [W-1:0] npc;
  logic         illegal;
  pc_state_e    state;

  pc_range_chk #(.W(W)) u_range_chk (
    .addr    (pc_q),
    .lo      (ADDR_LO),
    .hi      (ADDR_HI),
    .illegal (illegal)
  );

  assign pc_inc = pc_q + W'(4);

  always_comb begin
    npc = pc_inc;
    case (bus.npc_sel)
      NPC_SEQ: npc = pc_inc;
      NPC_BR:  npc = bus.br_target;
      NPC_J:   npc = bus.j_target;
      NPC_REG: npc = bus.reg_target;
      default: npc = pc_inc;
    endcase
  end

  // exc_req outranks everything; in FAULT it is the only way out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_VEC;
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          if (bus.exc_req) begin
            pc_q <= EXC_VEC;
          end else if (bus.eret) begin
            pc_q <= bus.epc;
          end else if (illegal) begin
            state <= ST_FAULT;
          end else if (!bus.stall) begin
            pc_q <= npc;
          end
        end
        ST_FAULT: begin
          if (bus.exc_req) begin
            pc_q  <= EXC_VEC;
            state <= ST_RUN;
          end
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_inc;
  assign bus.fetch_valid = ~illegal;
  assign bus.fetch_fault = (state == ST_FAULT);
  assign bus.exc_code    = illegal ? EXC_ADEL : EXC_NONE;

`ifdef PC_UNIT_FETCH_CNT_EN
  logic [31:0] fetch_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_q <= 32'd0;
    end else if ((state == ST_RUN) && !illegal && !bus.stall) begin
      fetch_cnt_q <= fetch_cnt_q + 32'd1;
    end
  end

  assign bus.fetch_cnt = fetch_cnt_q;
`endif

endmodule
